// File: rtl/des_pkg.sv
// Shared DES permutation constants: IP table, derived FP table, mode encoding.
// Used by des_perm_net and des_perm_pipe.
package des_pkg;

    localparam int BLOCK_W = 64;
    localparam int HALF_W  = 32;

    typedef enum logic [1:0] {
        MODE_IP  = 2'b00,
        MODE_FP  = 2'b01,
        MODE_BYP = 2'b10,
        MODE_ILL = 2'b11
    } mode_e;

    // Entry n names the source bit for result bit n, both in DES 1-based numbering.
    typedef int unsigned perm_tab_t [1:64];

    localparam perm_tab_t IP_TAB = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    function automatic perm_tab_t invert_tab(input perm_tab_t t);
        perm_tab_t r;
        for (int unsigned n = 1; n <= 64; n++) begin
            r[t[n]] = n;
        end
        return r;
    endfunction

    localparam perm_tab_t FP_TAB = invert_tab(IP_TAB);

endpackage

// File: rtl/des_perm_net.sv
// Combinational DES permutation network: IP, FP (= IP^-1) or bypass.
// Build option DES_PERM_SWAP_EN adds a swap input for the R16L16 half swap ahead of FP.
module des_perm_net
    import des_pkg::*;
(
    input  logic [BLOCK_W-1:0] data,
    input  mode_e              mode,
`ifdef DES_PERM_SWAP_EN
    input  logic               swap,
`endif
    output logic [BLOCK_W-1:0] result
);

    logic [BLOCK_W-1:0] src;

    always_comb begin
        src = data;
`ifdef DES_PERM_SWAP_EN
        if (swap && mode == MODE_FP) begin
            src = {data[HALF_W-1:0], data[BLOCK_W-1:HALF_W]};
        end
`endif
        result = src;
        // Bit n of the DES tables lives at vector index n-1.
        case (mode)
            MODE_IP: begin
                for (int n = 1; n <= BLOCK_W; n++) begin
                    result[n-1] = src[IP_TAB[n]-1];
                end
            end
            MODE_FP: begin
                for (int n = 1; n <= BLOCK_W; n++) begin
                    result[n-1] = src[FP_TAB[n]-1];
                end
            end
            default: result = src;
        endcase
    end

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined, valid/ready DES permutation unit with flush and illegal-mode drop.
// Build option DES_PERM_SWAP_EN adds the in_swap port (half swap before FP).
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [1:0]         in_mode,
`ifdef DES_PERM_SWAP_EN
    input  logic               in_swap,
`endif
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [HALF_W-1:0]  left_out,
    output logic [HALF_W-1:0]  right_out,
    output logic [TAG_W-1:0]   out_tag,
    output logic               mode_err,
    output logic               busy
);

    mode_e              mode;
    logic [BLOCK_W-1:0] perm_res;
    logic               accept;
    logic [STAGES:1]    v;
    logic [STAGES:1]    rdy;
    logic [BLOCK_W-1:0] data_q [1:STAGES];
    logic [TAG_W-1:0]   tag_q  [1:STAGES];

    assign mode = mode_e'(in_mode);

    des_perm_net u_net (
        .data   (in_data),
        .mode   (mode),
`ifdef DES_PERM_SWAP_EN
        .swap   (in_swap),
`endif
        .result (perm_res)
    );

    // rdy[k] means stage k may load this cycle: it is empty or its content moves on.
    always_comb begin : ready_chain
        logic downstream;
        downstream = out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            rdy[k]     = !v[k] || downstream;
            downstream = rdy[k];
        end
    end

    assign in_ready = rdy[1] && !flush && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            v        <= '0;
            mode_err <= 1'b0;
        end else begin
            // Illegal blocks are consumed but never occupy a stage.
            mode_err <= accept && (mode == MODE_ILL);
            if (flush) begin
                v <= '0;
            end else begin
                if (rdy[1]) begin
                    v[1] <= accept && (mode != MODE_ILL);
                end
                for (int k = 2; k <= STAGES; k++) begin
                    if (rdy[k]) begin
                        v[k] <= v[k-1];
                    end
                end
            end
        end
    end

    // NOTE: payload registers carry no reset; every consumer qualifies them with a valid bit.
    always_ff @(posedge clk) begin
        if (rdy[1]) begin
            data_q[1] <= perm_res;
            tag_q[1]  <= in_tag;
        end
        for (int k = 2; k <= STAGES; k++) begin
            if (rdy[k]) begin
                data_q[k] <= data_q[k-1];
                tag_q[k]  <= tag_q[k-1];
            end
        end
    end

    assign out_valid = v[STAGES];
    assign left_out  = data_q[STAGES][BLOCK_W-1:HALF_W];
    assign right_out = data_q[STAGES][HALF_W-1:0];
    assign out_tag   = tag_q[STAGES];
    assign busy      = |v;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Scoreboard bench for des_perm_pipe; define DES_PERM_SWAP_EN to exercise the swap port too.
module tb_des_perm_pipe;

    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [1:0]       in_mode;
    logic             in_swap_r;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      left_out;
    logic [31:0]      right_out;
    logic [TAG_W-1:0] out_tag;
    logic             mode_err;
    logic             busy;

    always #5 clk = ~clk;

    des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
`ifdef DES_PERM_SWAP_EN
        .in_swap   (in_swap_r),
`endif
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .left_out  (left_out),
        .right_out (right_out),
        .out_tag   (out_tag),
        .mode_err  (mode_err),
        .busy      (busy)
    );

    typedef struct packed {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sb_q [$];
    logic [63:0] cap_q [$];
    exp_t        mon_e;
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          out_cnt    = 0;
    int          err_cnt    = 0;
    int          ready_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] perm_ip(input logic [63:0] d);
        logic [63:0] r;
        for (int n = 0; n < 64; n++) r[n] = d[IP_T[n]-1];
        return r;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] d);
        logic [63:0] r;
        for (int n = 0; n < 64; n++) r[IP_T[n]-1] = d[n];
        return r;
    endfunction

    // out_ready pattern: 0 = always ready, 1 = toggle each cycle, else held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mode_err) err_cnt++;
        if (out_valid && out_ready) begin
            out_cnt++;
            cap_q.push_back({left_out, right_out});
            if (sb_q.size() == 0) begin
                check("unexpected_output", {left_out, right_out}, 64'h0 ^ {left_out, right_out} ^ 64'h1);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_data", {left_out, right_out}, mon_e.data);
                check("out_tag", 64'(out_tag), 64'(mon_e.tag));
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [1:0] m, input logic [TAG_W-1:0] t,
                        input logic s, input logic [63:0] exp);
        int cnt = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        in_tag    = t;
        in_swap_r = s;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_ready && cnt < 200);
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        else if (m != 2'b11) sb_q.push_back('{data: exp, tag: t});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while ((sb_q.size() != 0 || busy) && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("drain", 64'(sb_q.size() == 0 && !busy), 64'd1);
    endtask

    task automatic fill_stalled();
        logic [63:0] d;
        ready_mode = 2;
        repeat (2) @(posedge clk);
        for (int i = 0; i < ((STAGES < 3) ? STAGES : 3); i++) begin
            d = {$urandom, $urandom};
            send(d, 2'b00, TAG_W'(i), 1'b0, perm_ip(d));
        end
    endtask

    // Abort a stalled, full pipeline by flush or reset while a new block is offered.
    task automatic abort_test(input bit use_reset);
        int c0;
        int e0;
        fill_stalled();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 64'hdead_beef_0bad_f00d;
        in_mode  = use_reset ? 2'b00 : 2'b11;
        in_tag   = 4'hf;
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        check(use_reset ? "reset_in_ready" : "flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check(use_reset ? "reset_out_valid" : "flush_out_valid", 64'(out_valid), 64'd0);
        check(use_reset ? "reset_busy" : "flush_busy", 64'(busy), 64'd0);
        check(use_reset ? "reset_mode_err" : "flush_mode_err", 64'(mode_err), 64'd0);
        sb_q.delete();
        c0 = out_cnt;
        e0 = err_cnt;
        ready_mode = 0;
        repeat (STAGES + 4) @(negedge clk);
        check(use_reset ? "reset_no_output" : "flush_no_output", 64'(out_cnt - c0), 64'd0);
        check(use_reset ? "reset_no_err" : "flush_no_err", 64'(err_cnt - e0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] orig [1000];

    initial begin : main
        int cnt;
        int ready_seen;
        int c0;
        int e0;
        logic [63:0] d;
        logic [63:0] y;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_mode = '0; in_tag = '0; in_swap_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mode_err", 64'(mode_err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single bit through IP: in bit 1 lands on result bit 40.
        send(64'h1, 2'b00, 4'h1, 1'b0, perm_ip(64'h1));
        idle();
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 20);
        check("latency", 64'(cnt), 64'(STAGES));
        check("ip_bit1_left", 64'(left_out), 64'h0000_0080);
        check("ip_bit1_right", 64'(right_out), 64'h0);
        wait_drain();

        // IP then FP round trip, plus bypass.
        cap_q.delete();
        for (int i = 0; i < 1000; i++) begin
            orig[i] = {$urandom, $urandom};
            send(orig[i], 2'b00, TAG_W'(i), 1'b0, perm_ip(orig[i]));
        end
        idle();
        wait_drain();
        check("ip_count", 64'(cap_q.size()), 64'd1000);
        for (int i = 0; i < 1000; i++) begin
            send(cap_q[i], 2'b01, TAG_W'(i + 3), 1'b0, orig[i]);
        end
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            send(d, 2'b10, TAG_W'(i), 1'b0, d);
        end
        idle();
        wait_drain();

        // Backpressure: toggled out_ready, then held low until in_ready drops.
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            send(d, 2'b00, TAG_W'(i), 1'b0, perm_ip(d));
        end
        idle();
        wait_drain();
        ready_mode = 2;
        repeat (2) @(posedge clk);
        for (int i = 0; i < STAGES; i++) begin
            d = {$urandom, $urandom};
            send(d, 2'b00, TAG_W'(8 + i), 1'b0, perm_ip(d));
        end
        @(posedge clk);
        #1;
        d = {$urandom, $urandom};
        in_valid = 1'b1; in_data = d; in_mode = 2'b00; in_tag = 4'he;
        ready_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready) ready_seen++;
        end
        check("full_in_ready_low", 64'(ready_seen), 64'd0);
        check("held_out_valid", 64'(out_valid), 64'd1);
        check("held_busy", 64'(busy), 64'd1);
        check("held_data", {left_out, right_out}, sb_q[0].data);
        ready_mode = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_ready && cnt < 20);
        check("release_in_ready", 64'(in_ready), 64'd1);
        sb_q.push_back('{data: perm_fp(perm_fp(perm_ip(perm_ip(d)))), tag: 4'he});
        sb_q[sb_q.size()-1].data = perm_ip(d);
        idle();
        wait_drain();

        // Illegal mode between two IP blocks.
        c0 = out_cnt;
        e0 = err_cnt;
        d = 64'h0123_4567_89ab_cdef;
        send(d, 2'b00, 4'h3, 1'b0, perm_ip(d));
        send(~d, 2'b11, 4'h4, 1'b0, 64'h0);
        send(d ^ 64'hffff, 2'b00, 4'h5, 1'b0, perm_ip(d ^ 64'hffff));
        idle();
        wait_drain();
        repeat (3) @(negedge clk);
        check("ill_mode_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("ill_outputs", 64'(out_cnt - c0), 64'd2);

        abort_test(1'b0);
        abort_test(1'b1);
        check("post_abort_in_ready", 64'(in_ready), 64'd1);

`ifdef DES_PERM_SWAP_EN
        d = 64'h1 << 57;
        send(d, 2'b00, 4'h6, 1'b0, 64'h1);
        d = {$urandom, $urandom};
        y = perm_ip(d);
        send({y[31:0], y[63:32]}, 2'b01, 4'h7, 1'b1, d);
        send(d, 2'b10, 4'h8, 1'b1, d);
        idle();
        wait_drain();
`else
        y = 64'h0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
